wrapper_packet_fifo: RTL and testbench

- Valid/ready packet buffer inserted on the packet bus between wrapper_packet_construct (upstream) and the accelerator engine or wrapper_packet_deconstruct (downstream).
- Decouples the producer and consumer.
- Absorbs bursts of up to DEPTH beats.
- Preserves each beat's last flag so packet boundaries pass through unchanged.

---
 rtl/wrapper_packet_fifo.sv | 118 +++++++++++
 tb/tb_wrapper_packet_fifo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/wrapper_packet_fifo.sv
// Valid/ready packet beat FIFO between packet construct and the engine/deconstruct stage.
// Define WRAPPER_PACKET_FIFO_STORE_FWD_EN to hold beats back until a whole packet is stored.
module wrapper_packet_fifo #(
    parameter int PACKETWIDTH = 512,
    parameter int DEPTH       = 4
) (
    input  logic                       hclk,
    input  logic                       hresetn,
    input  logic [PACKETWIDTH-1:0]     in_packet_data,
    input  logic                       in_packet_data_last,
    input  logic                       in_packet_data_valid,
    output logic                       in_packet_data_ready,
    output logic [PACKETWIDTH-1:0]     out_packet_data,
    output logic                       out_packet_data_last,
    output logic                       out_packet_data_valid,
    input  logic                       out_packet_data_ready,
    output logic [$clog2(DEPTH):0]     fill_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PACKETWIDTH:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [PACKETWIDTH:0] head_s;
    logic                 push_s;
    logic                 pop_s;

    assign head_s               = mem_q[rd_ptr_q];
    assign out_packet_data      = head_s[PACKETWIDTH-1:0];
    assign out_packet_data_last = head_s[PACKETWIDTH];
    assign fill_level           = count_q;
    // Ready looks only at the stored count, so a pop never frees a slot in the same cycle.
    assign in_packet_data_ready = (count_q != FULL_CNT);
    assign push_s               = in_packet_data_valid & in_packet_data_ready;
    assign pop_s                = out_packet_data_valid & out_packet_data_ready;

`ifdef WRAPPER_PACKET_FIFO_STORE_FWD_EN
    logic [CW-1:0] pkt_count_q, pkt_count_d;

    // Release the head only once a full packet is held, or when full so long packets cut through.
    assign out_packet_data_valid = (count_q != CW'(0)) &
                                   ((pkt_count_q != CW'(0)) | (count_q == FULL_CNT));

    // Complete-packet counter next state.
    always_comb begin
        pkt_count_d = pkt_count_q;
        case ({push_s & in_packet_data_last, pop_s & head_s[PACKETWIDTH]})
            2'b10:   pkt_count_d = pkt_count_q + CW'(1);
            2'b01:   pkt_count_d = pkt_count_q - CW'(1);
            default: pkt_count_d = pkt_count_q;
        endcase
    end

    // Complete-packet counter register.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            pkt_count_q <= CW'(0);
        end else begin
            pkt_count_q <= pkt_count_d;
        end
    end
`else
    assign out_packet_data_valid = (count_q != CW'(0));
`endif

    // Pointer and occupancy next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= CW'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Beat storage; cleared on reset so the head output is never X.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= {in_packet_data_last, in_packet_data};
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

endmodule

// File: tb/tb_wrapper_packet_fifo.sv
// Scoreboard bench for wrapper_packet_fifo; follows WRAPPER_PACKET_FIFO_STORE_FWD_EN when defined.
module tb_wrapper_packet_fifo;

    localparam int PW    = 512;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          hclk = 1'b0;
    logic          hresetn = 1'b0;
    logic [PW-1:0] in_packet_data = '0;
    logic          in_packet_data_last = 1'b0;
    logic          in_packet_data_valid = 1'b0;
    logic          in_packet_data_ready;
    logic [PW-1:0] out_packet_data;
    logic          out_packet_data_last;
    logic          out_packet_data_valid;
    logic          out_packet_data_ready = 1'b0;
    logic [CW-1:0] fill_level;

    int total = 0;
    int bad = 0;
    logic [PW:0] sb_q[$];
    int cnt = 0;
    int pktc = 0;

    wrapper_packet_fifo #(.PACKETWIDTH(PW), .DEPTH(DEPTH)) dut (
        .hclk                 (hclk),
        .hresetn              (hresetn),
        .in_packet_data       (in_packet_data),
        .in_packet_data_last  (in_packet_data_last),
        .in_packet_data_valid (in_packet_data_valid),
        .in_packet_data_ready (in_packet_data_ready),
        .out_packet_data      (out_packet_data),
        .out_packet_data_last (out_packet_data_last),
        .out_packet_data_valid(out_packet_data_valid),
        .out_packet_data_ready(out_packet_data_ready),
        .fill_level           (fill_level)
    );

    always #5 hclk = ~hclk;

    task automatic check_eq(input string tag, input logic [527:0] obs, input logic [527:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_valid();
        if (cnt == 0) return 1'b0;
`ifdef WRAPPER_PACKET_FIFO_STORE_FWD_EN
        return (pktc != 0) || (cnt == DEPTH);
`else
        return 1'b1;
`endif
    endfunction

    // Called at a falling edge with inputs already driven: check, update model, advance one cycle.
    task automatic step(output bit acc);
        bit          push;
        bit          pop;
        bit          mv;
        logic [PW:0] head;
        mv = model_valid();
        check_eq("in_ready", 528'(in_packet_data_ready), 528'(cnt != DEPTH));
        check_eq("out_valid", 528'(out_packet_data_valid), 528'(mv));
        check_eq("fill_level", 528'(fill_level), 528'(cnt));
        head = '0;
        if (mv) begin
            head = sb_q[0];
            check_eq("head_data", 528'(out_packet_data), 528'(head[PW-1:0]));
            check_eq("head_last", 528'(out_packet_data_last), 528'(head[PW]));
        end
        push = in_packet_data_valid && (cnt != DEPTH);
        pop  = mv && out_packet_data_ready;
        if (pop) begin
            if (head[PW]) pktc--;
            sb_q.delete(0);
            cnt--;
        end
        if (push) begin
            sb_q.push_back({in_packet_data_last, in_packet_data});
            if (in_packet_data_last) pktc++;
            cnt++;
        end
        acc = push;
        @(posedge hclk);
        @(negedge hclk);
    endtask

    task automatic send(input int n, input logic [PW-1:0] base);
        int k = 0;
        int budget = 0;
        bit acc;
        while (k < n && budget < 64) begin
            in_packet_data_valid = 1'b1;
            in_packet_data       = base + PW'(k);
            in_packet_data_last  = (k == n - 1);
            step(acc);
            if (acc) k++;
            budget++;
        end
        in_packet_data_valid = 1'b0;
        in_packet_data_last  = 1'b0;
        check_eq("send_done", 528'(k), 528'(n));
    endtask

    task automatic idle(input int n);
        bit acc;
        in_packet_data_valid = 1'b0;
        repeat (n) step(acc);
    endtask

    task automatic drain();
        int budget = 0;
        bit acc;
        in_packet_data_valid  = 1'b0;
        out_packet_data_ready = 1'b1;
        while (cnt != 0 && budget < 32) begin
            step(acc);
            budget++;
        end
        check_eq("drained", 528'(cnt), 528'(0));
    endtask

    task automatic do_reset(input int n);
        in_packet_data_valid = 1'b0;
        hresetn = 1'b0;
        repeat (n) @(posedge hclk);
        @(negedge hclk);
        sb_q.delete();
        cnt  = 0;
        pktc = 0;
        hresetn = 1'b1;
    endtask

    initial begin
        // Reset and idle.
        do_reset(2);
        out_packet_data_ready = 1'b1;
        idle(3);

        // Single beat.
        send(1, {16{32'hA5A5_A5A5}});
        idle(2);

        // Fill to full, fifth beat refused, then drain in order.
        out_packet_data_ready = 1'b0;
        send(2, PW'(1));
        send(2, PW'(3));
        in_packet_data_valid = 1'b1;
        in_packet_data       = PW'(5);
        in_packet_data_last  = 1'b1;
        idle_hold(2);
        in_packet_data_valid = 1'b0;
        drain();
        idle(1);

        // Continuous push/pop across several pointer wraps.
        out_packet_data_ready = 1'b1;
        for (int i = 0; i < 20; i++) send(1, PW'(100 + i));
        idle(2);

        // Backpressure: head held while two more beats arrive.
        out_packet_data_ready = 1'b0;
        send(1, PW'(32'h1234));
        send(1, PW'(32'h2000));
        send(1, PW'(32'h3000));
        idle(7);
        drain();

        // Packet-level release and a packet longer than the FIFO.
        out_packet_data_ready = 1'b1;
        send(3, PW'(32'h0300));
        drain();
        send(6, PW'(32'h0600));
        drain();

        // Reset in the middle of traffic discards buffered beats.
        out_packet_data_ready = 1'b0;
        send(2, PW'(32'h0900));
        do_reset(1);
        out_packet_data_ready = 1'b1;
        idle(2);
        send(1, PW'(32'h0A00));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Keeps the currently driven beat asserted for n cycles without changing it.
    task automatic idle_hold(input int n);
        bit acc;
        repeat (n) step(acc);
    endtask

endmodule
